// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the two-requester memory arbiter:
//   state_e   - arbiter FSM states (IDLE / ISSUE / RESP)
//   REQ_M0/1  - requester index constants (also the encoding of a grant)
//   MASK_W    - byte-write mask width
//   req_pending() - helper: a requester is pending on a read or any write
// Configuration macro used by the files that import this package:
//   MEM_ARB_FIXED_PRIO_EN - m0 wins every tie, no last-grant state
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  localparam logic REQ_M0 = 1'b0;
  localparam logic REQ_M1 = 1'b1;

  localparam int MASK_W = 4;

  function automatic logic req_pending(input logic rstrb, input logic [MASK_W-1:0] wmask);
    return rstrb | (|wmask);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Combinational two-way round-robin grant decision.
// Ports:
//   req_i        [1:0]  pending requests, bit N = requester N
//   last_grant_i        index of the requester granted most recently
//   valid_o             at least one request is pending
//   grant_o             index of the winning requester (meaningful when valid_o)
// A single pending request always wins; on a tie the requester that was not
// granted last wins. Tying last_grant_i to REQ_M1 yields fixed m0 priority.
// -----------------------------------------------------------------------------
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       valid_o,
  output logic       grant_o
);

  always_comb begin
    valid_o = |req_i;
    grant_o = REQ_M0;
    if (req_i == 2'b11) begin
      grant_o = ~last_grant_i;
    end else if (req_i[1]) begin
      grant_o = REQ_M1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port RAM between requester 0 (processor) and requester 1
// (loader/debug). Each access takes three cycles: IDLE (arbitrate and latch),
// ISSUE (one-cycle RAM strobe), RESP (one-cycle done pulse, read data passed
// straight through from the RAM).
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   mN_addr/rstrb/wmask/wdata       requester N request (level, held to done)
//   mN_rdata, mN_done               requester N response
//   mem_addr/rstrb/wmask/wdata      RAM request (strobes active in ISSUE only)
//   mem_rdata                       RAM read data, valid cycle after mem_rstrb
// Configuration:
//   MEM_ARB_FIXED_PRIO_EN  defined: m0 wins every tie (no last-grant register)
//                          undefined: round-robin between m0 and m1
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   m0_addr,
  input  logic              m0_rstrb,
  input  logic [MASK_W-1:0] m0_wmask,
  input  logic [XLEN-1:0]   m0_wdata,
  output logic [XLEN-1:0]   m0_rdata,
  output logic              m0_done,
  input  logic [XLEN-1:0]   m1_addr,
  input  logic              m1_rstrb,
  input  logic [MASK_W-1:0] m1_wmask,
  input  logic [XLEN-1:0]   m1_wdata,
  output logic [XLEN-1:0]   m1_rdata,
  output logic              m1_done,
  output logic [XLEN-1:0]   mem_addr,
  output logic              mem_rstrb,
  output logic [MASK_W-1:0] mem_wmask,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata
);

  // Requester ports gathered into arrays so both sides share one code path.
  logic [XLEN-1:0]   req_addr  [2];
  logic [XLEN-1:0]   req_wdata [2];
  logic [MASK_W-1:0] req_wmask [2];
  logic              req_rstrb [2];
  logic [1:0]        pend;
  logic [1:0]        done_vec;
  logic [XLEN-1:0]   rdata_vec [2];

  assign req_addr[0]  = m0_addr;
  assign req_addr[1]  = m1_addr;
  assign req_wdata[0] = m0_wdata;
  assign req_wdata[1] = m1_wdata;
  assign req_wmask[0] = m0_wmask;
  assign req_wmask[1] = m1_wmask;
  assign req_rstrb[0] = m0_rstrb;
  assign req_rstrb[1] = m1_rstrb;

  state_e            state_q;
  logic              owner_q;
  logic              is_read_q;
  logic              done_q;
  logic [XLEN-1:0]   mem_addr_q;
  logic [XLEN-1:0]   mem_wdata_q;
  logic [MASK_W-1:0] mem_wmask_q;
  logic              mem_rstrb_q;

  logic              arb_valid;
  logic              arb_grant;
  logic              last_grant;

`ifdef MEM_ARB_FIXED_PRIO_EN
  // Pretending m1 was always granted last makes m0 win every tie.
  assign last_grant = REQ_M1;
`else
  logic last_grant_q;
  assign last_grant = last_grant_q;
`endif

  rr_arb2 u_arb (
    .req_i        (pend),
    .last_grant_i (last_grant),
    .valid_o      (arb_valid),
    .grant_o      (arb_grant)
  );

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
      assign pend[gi]      = req_pending(req_rstrb[gi], req_wmask[gi]);
      assign done_vec[gi]  = done_q && (owner_q == 1'(gi));
      // Read data is a pure pass-through of the RAM, gated to the owner's
      // done cycle so nothing leaks to the other requester.
      assign rdata_vec[gi] = (done_vec[gi] && is_read_q) ? mem_rdata : '0;
    end
  endgenerate

  assign m0_done   = done_vec[0];
  assign m1_done   = done_vec[1];
  assign m0_rdata  = rdata_vec[0];
  assign m1_rdata  = rdata_vec[1];
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wmask = mem_wmask_q;
  assign mem_rstrb = mem_rstrb_q;

  // Strobes are loaded on the IDLE->ISSUE edge and cleared on ISSUE->RESP,
  // so they are high for exactly the ISSUE cycle. Reset wins over everything,
  // abandoning any access in flight without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= REQ_M0;
      is_read_q   <= 1'b0;
      done_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      mem_rstrb_q <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      last_grant_q <= REQ_M1;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (arb_valid) begin
            owner_q     <= arb_grant;
            mem_addr_q  <= req_addr[arb_grant];
            mem_wdata_q <= req_wdata[arb_grant];
            // Any write mask makes this a write; rstrb is then ignored.
            mem_wmask_q <= req_wmask[arb_grant];
            mem_rstrb_q <= (req_wmask[arb_grant] == '0);
            is_read_q   <= (req_wmask[arb_grant] == '0);
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_grant_q <= arb_grant;
`endif
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          mem_wmask_q <= '0;
          mem_rstrb_q <= 1'b0;
          done_q      <= 1'b1;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          mem_wmask_q <= '0;
          mem_rstrb_q <= 1'b0;
          done_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter: a table of single-requester transactions
// with hand-computed RAM strobes and read data, followed by hand-written
// sequences for withdrawal, arbitration order, reset during ISSUE and idling.
// A small byte-writable RAM with registered read sits on the mem_* side.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m0_rstrb, m0_done;
  logic [3:0]  m0_wmask;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        m1_rstrb, m1_done;
  logic [3:0]  m1_wmask;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rstrb;
  logic [3:0]  mem_wmask;
  logic        ram_init;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.XLEN(32)) dut (
    .clk       (clk),
    .reset     (rst),
    .m0_addr   (m0_addr),
    .m0_rstrb  (m0_rstrb),
    .m0_wmask  (m0_wmask),
    .m0_wdata  (m0_wdata),
    .m0_rdata  (m0_rdata),
    .m0_done   (m0_done),
    .m1_addr   (m1_addr),
    .m1_rstrb  (m1_rstrb),
    .m1_wmask  (m1_wmask),
    .m1_wdata  (m1_wdata),
    .m1_rdata  (m1_rdata),
    .m1_done   (m1_done),
    .mem_addr  (mem_addr),
    .mem_rstrb (mem_rstrb),
    .mem_wmask (mem_wmask),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment RAM: 64 words, byte writes, read data one cycle after rstrb.
  logic [31:0] ram [0:63];
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 64; i++) ram[i] <= 32'h0;
      ram[4] <= 32'hDEAD_BEEF;   // 0x10
      ram[8] <= 32'hAAAA_BBBB;   // 0x20
      mem_rdata <= 32'h0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) ram[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      if (mem_rstrb) mem_rdata <= ram[mem_addr[7:2]];
    end
  end

  typedef struct {
    logic        who;
    logic [31:0] addr;
    logic        rstrb;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic        exp_rstrb;
    logic [3:0]  exp_wmask;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    m0_addr = '0; m0_rstrb = 1'b0; m0_wmask = '0; m0_wdata = '0;
    m1_addr = '0; m1_rstrb = 1'b0; m1_wmask = '0; m1_wdata = '0;
  endtask

  task automatic drive(input vec_t v);
    clear_reqs();
    if (v.who == 1'b0) begin
      m0_addr = v.addr; m0_rstrb = v.rstrb; m0_wmask = v.wmask; m0_wdata = v.wdata;
    end else begin
      m1_addr = v.addr; m1_rstrb = v.rstrb; m1_wmask = v.wmask; m1_wdata = v.wdata;
    end
  endtask

  // One transaction starting from IDLE and ending back in IDLE.
  task automatic run_txn(input int idx, input vec_t v);
    logic own_done, oth_done;
    logic [31:0] own_rdata, oth_rdata;
    drive(v);
    tick();  // IDLE sampled -> ISSUE
    check($sformatf("v%0d_issue_rstrb", idx), 32'(mem_rstrb), 32'(v.exp_rstrb));
    check($sformatf("v%0d_issue_wmask", idx), 32'(mem_wmask), 32'(v.exp_wmask));
    check($sformatf("v%0d_issue_addr", idx), mem_addr, v.addr);
    check($sformatf("v%0d_issue_wdata", idx), mem_wdata, v.wdata);
    check($sformatf("v%0d_issue_done", idx), 32'({m1_done, m0_done}), 32'h0);
    tick();  // ISSUE -> RESP
    own_done  = v.who ? m1_done  : m0_done;
    oth_done  = v.who ? m0_done  : m1_done;
    own_rdata = v.who ? m1_rdata : m0_rdata;
    oth_rdata = v.who ? m0_rdata : m1_rdata;
    check($sformatf("v%0d_resp_done", idx), 32'(own_done), 32'h1);
    check($sformatf("v%0d_resp_other_done", idx), 32'(oth_done), 32'h0);
    check($sformatf("v%0d_resp_rdata", idx), own_rdata, v.exp_rdata);
    check($sformatf("v%0d_resp_other_rdata", idx), oth_rdata, 32'h0);
    check($sformatf("v%0d_resp_strobes", idx), 32'({mem_rstrb, mem_wmask}), 32'h0);
    $display("txn %0d: m%0d addr=%h wmask=%h rstrb=%0d -> rdata=%h done=%0d",
             idx, v.who, v.addr, v.wmask, v.rstrb, own_rdata, own_done);
    clear_reqs();
    tick();  // RESP -> IDLE
    check($sformatf("v%0d_idle_done", idx), 32'({m1_done, m0_done}), 32'h0);
  endtask

  initial begin
    logic        found;
    logic        exp_who;
    logic        got_who;
    logic [31:0] got_rdata;

    // who addr rstrb wmask wdata | exp_rstrb exp_wmask exp_rdata
    vecs[0] = '{1'b0, 32'h10, 1'b1, 4'h0, 32'h0,          1'b1, 4'h0, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 32'h20, 1'b0, 4'h3, 32'h1234_5678,  1'b0, 4'h3, 32'h0};
    vecs[2] = '{1'b0, 32'h20, 1'b1, 4'h0, 32'h0,          1'b1, 4'h0, 32'hAAAA_5678};
    vecs[3] = '{1'b0, 32'h24, 1'b1, 4'hF, 32'hCAFE_F00D,  1'b0, 4'hF, 32'h0};
    vecs[4] = '{1'b1, 32'h24, 1'b1, 4'h0, 32'h0,          1'b1, 4'h0, 32'hCAFE_F00D};
    vecs[5] = '{1'b1, 32'h28, 1'b0, 4'hC, 32'h1122_3344,  1'b0, 4'hC, 32'h0};
    vecs[6] = '{1'b0, 32'h28, 1'b1, 4'h0, 32'h0,          1'b1, 4'h0, 32'h1122_0000};

    clear_reqs();
    rst = 1'b1;
    ram_init = 1'b1;
    tick();
    tick();
    check("reset_mem_rstrb", 32'(mem_rstrb), 32'h0);
    check("reset_mem_wmask", 32'(mem_wmask), 32'h0);
    check("reset_mem_addr", mem_addr, 32'h0);
    check("reset_mem_wdata", mem_wdata, 32'h0);
    check("reset_done", 32'({m1_done, m0_done}), 32'h0);
    check("reset_rdata", m0_rdata | m1_rdata, 32'h0);
    rst = 1'b0;
    ram_init = 1'b0;

    for (int i = 0; i < 7; i++) run_txn(i, vecs[i]);

    // Request withdrawn right after being granted still completes.
    m1_addr = 32'h2C; m1_wmask = 4'hF; m1_wdata = 32'h55AA_55AA;
    tick();
    clear_reqs();
    check("withdraw_issue_wmask", 32'(mem_wmask), 32'hF);
    tick();
    check("withdraw_done", 32'(m1_done), 32'h1);
    tick();
    check("withdraw_idle", 32'({m1_done, m0_done, mem_rstrb, mem_wmask}), 32'h0);
    $display("txn withdraw: m1 write 0x2c completed after request dropped");

    // Both pending right after reset: m0 first, then alternate (or m0 always
    // with fixed priority). The last grant before this reset was m1, so a
    // missing reset of the last-grant state would show up here too.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m0_addr = 32'h10; m0_rstrb = 1'b1;
    m1_addr = 32'h20; m1_rstrb = 1'b1;
    for (int k = 0; k < 4; k++) begin
      found = 1'b0;
      for (int c = 0; c < 6 && !found; c++) begin
        tick();
        if (m0_done || m1_done) found = 1'b1;
      end
      check($sformatf("arb%0d_timeout", k), 32'(found), 32'h1);
      if (found) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        exp_who = 1'b0;
`else
        exp_who = (k % 2 == 1);
`endif
        got_who   = m1_done;
        got_rdata = got_who ? m1_rdata : m0_rdata;
        check($sformatf("arb%0d_both_done", k), 32'(m0_done & m1_done), 32'h0);
        check($sformatf("arb%0d_winner", k), 32'(got_who), 32'(exp_who));
        check($sformatf("arb%0d_rdata", k), got_rdata,
              got_who ? 32'hAAAA_5678 : 32'hDEAD_BEEF);
        $display("txn arb%0d: m%0d served rdata=%h", k, got_who, got_rdata);
      end
    end
    clear_reqs();
    tick();

    // Reset asserted during ISSUE of an m1 read abandons it.
    m1_addr = 32'h10; m1_rstrb = 1'b1;
    tick();
    check("rstissue_rstrb", 32'(mem_rstrb), 32'h1);
    rst = 1'b1;
    clear_reqs();
    tick();
    check("rstissue_done", 32'({m1_done, m0_done}), 32'h0);
    check("rstissue_strobes", 32'({mem_rstrb, mem_wmask}), 32'h0);
    check("rstissue_addr", mem_addr, 32'h0);
    check("rstissue_wdata", mem_wdata, 32'h0);
    check("rstissue_rdata", m0_rdata | m1_rdata, 32'h0);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("rstissue_after%0d", c), 32'({m1_done, m0_done}), 32'h0);
    end
    $display("txn rst_in_issue: m1 read abandoned");

    // Twenty idle cycles: no strobes, no done.
    for (int c = 0; c < 20; c++) begin
      tick();
      check($sformatf("idle%0d", c), 32'({mem_rstrb, mem_wmask, m1_done, m0_done}), 32'h0);
    end
    $display("txn idle: 20 cycles without requests");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
